slice_serial_adder: RTL and testbench

SLICE_SERIAL_ADDER -- requirements
Module: slice_serial_adder

---
 rtl/slice_serial_adder.sv | 139 +++++++++++++
 tb/tb_slice_serial_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/slice_serial_adder.sv
// Bit-serial-by-slice adder: adds WIDTH-bit operands 3 bits per clock using carry-lookahead slices.
// Optional macro SLICE_SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output io_ovf.
module slice_serial_adder #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic             io_c_in,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_s,
    output logic             io_c_out,
`ifdef SLICE_SERIAL_ADDER_OVF_EN
    output logic             io_ovf,
`endif
    output logic             io_pg,
    output logic             io_busy
);

    // state | meaning
    // IDLE  | waiting for an operand set (io_in_ready high once reset is synchronized)
    // RUN   | one 3-bit slice added per cycle, slice index k counts up
    // DONE  | result held on io_s/io_c_out/io_pg until io_out_ready

    localparam int NSLICE = WIDTH / 3;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             rst_meta;
    logic             rst_sync;
    logic             in_ready_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k;

    logic [2:0] sa;
    logic [2:0] sb;
    logic [2:0] g;
    logic [2:0] p;
    logic [3:0] c;
    logic [2:0] sum;

    // Release is synchronized so the FSM cannot accept on a metastable reset edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    always_comb begin
        sa   = a_q[3*k +: 3];
        sb   = b_q[3*k +: 3];
        g    = sa & sb;
        p    = sa | sb;
        c[0] = io_c_out;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        sum  = sa ^ sb ^ c[2:0];
    end

    assign io_in_ready = in_ready_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            k            <= '0;
            io_c_out     <= 1'b0;
            io_s         <= '0;
            io_pg        <= 1'b0;
            io_out_valid <= 1'b0;
            io_busy      <= 1'b0;
`ifdef SLICE_SERIAL_ADDER_OVF_EN
            io_ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready_q && io_in_valid) begin
                        a_q        <= io_a;
                        b_q        <= io_b;
                        io_c_out   <= io_c_in;
                        k          <= '0;
                        io_pg      <= 1'b1;
                        io_busy    <= 1'b1;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end else begin
                        in_ready_q <= rst_sync;
                    end
                end
                RUN: begin
                    io_s[3*k +: 3] <= sum;
                    io_c_out       <= c[3];
                    io_pg          <= io_pg & (&p);
                    k              <= k + 1'b1;
                    if (k == K_LAST) begin
                        io_busy      <= 1'b0;
                        io_out_valid <= 1'b1;
`ifdef SLICE_SERIAL_ADDER_OVF_EN
                        // carry into the MSB is c[2] of the top slice
                        io_ovf       <= c[2] ^ c[3];
`endif
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        io_out_valid <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_serial_adder.sv
// Randomized self-checking bench for slice_serial_adder against an arithmetic reference (A+B+c_in).
module tb_slice_serial_adder;

    localparam int W  = 12;
    localparam int NS = W / 3;

    logic         clock;
    logic         reset;
    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_a;
    logic [W-1:0] io_b;
    logic         io_c_in;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_s;
    logic         io_c_out;
    logic         io_pg;
    logic         io_busy;
`ifdef SLICE_SERIAL_ADDER_OVF_EN
    logic         io_ovf;
`endif

    int n_vec;
    int n_err;

    slice_serial_adder #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_a         (io_a),
        .io_b         (io_b),
        .io_c_in      (io_c_in),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_s         (io_s),
        .io_c_out     (io_c_out),
`ifdef SLICE_SERIAL_ADDER_OVF_EN
        .io_ovf       (io_ovf),
`endif
        .io_pg        (io_pg),
        .io_busy      (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {ovf, pg, c_out, s}
    function automatic logic [W+2:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] full;
        logic       pg;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        pg   = &(a | b);
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, pg, full[W], full[W-1:0]};
    endfunction

    // Waits for io_in_ready, offers the operands, returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int cyc;
        cyc = 0;
        while (!io_in_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("in_ready_timeout", 64'(cyc < 50), 64'd1);
        io_a        = a;
        io_b        = b;
        io_c_in     = ci;
        io_in_valid = 1'b1;
        @(negedge clock);
        io_in_valid = 1'b0;
        io_a        = W'($urandom);
        io_b        = W'($urandom);
        io_c_in     = 1'($urandom);
    endtask

    // Runs to DONE with noise on the ignored inputs, checks result, stalls, then retires it.
    task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                             input int stall, input string tag);
        logic [W+2:0] e;
        int           cyc;
        e   = ref_add(a, b, ci);
        cyc = 0;
        while (!io_out_valid && cyc < 40) begin
            if (cyc == 0) check({tag, "_busy"}, 64'(io_busy), 64'd1);
            io_out_ready = 1'($urandom);
            io_in_valid  = 1'($urandom);
            @(negedge clock);
            cyc++;
        end
        io_out_ready = 1'b0;
        io_in_valid  = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(NS));
        if (!io_out_valid) return;
        check({tag, "_s"}, 64'(io_s), 64'(e[W-1:0]));
        check({tag, "_cout"}, 64'(io_c_out), 64'(e[W]));
        check({tag, "_pg"}, 64'(io_pg), 64'(e[W+1]));
`ifdef SLICE_SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(io_ovf), 64'(e[W+2]));
`endif
        for (int i = 0; i < stall; i++) begin
            io_in_valid = 1'($urandom);
            io_a        = W'($urandom);
            @(negedge clock);
            check({tag, "_hold_valid"}, 64'(io_out_valid), 64'd1);
            check({tag, "_hold_s"}, 64'(io_s), 64'(e[W-1:0]));
            check({tag, "_hold_ready"}, 64'(io_in_ready), 64'd0);
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
        check({tag, "_retired"}, 64'(io_out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(io_in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int stall, input string tag);
        start_op(a, b, ci);
        finish_op(a, b, ci, stall, tag);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;
        io_a         = '0;
        io_b         = '0;
        io_c_in      = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_out_valid", 64'(io_out_valid), 64'd0);
        check("rst_busy", 64'(io_busy), 64'd0);
        check("rst_s", 64'(io_s), 64'd0);
        check("rst_pg", 64'(io_pg), 64'd0);
        check("rst_cout", 64'(io_c_out), 64'd0);
        reset = 1'b1;

        do_op(12'hFFF, 12'h001, 1'b0, 0, "wrap");
        do_op(12'h123, 12'h456, 1'b1, 10, "stall10");
        do_op(12'h000, 12'h000, 1'b0, 1, "zero");
        do_op(12'hFFF, 12'hFFF, 1'b1, 2, "allones");
        do_op(12'h7FF, 12'h001, 1'b0, 0, "ovf_pos");
        do_op(12'h800, 12'h800, 1'b0, 0, "ovf_neg");

        // Reset in the second RUN cycle abandons the operation.
        start_op(12'h5A5, 12'h3C3, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrun_out_valid", 64'(io_out_valid), 64'd0);
        check("midrun_busy", 64'(io_busy), 64'd0);
        check("midrun_s", 64'(io_s), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        do_op(12'h001, 12'h001, 1'b0, 0, "after_rst");

        for (int n = 0; n < 3000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
